mel_frame_reader: RTL

MEL_FRAME_READER -- requirements
Module: mel_frame_reader

---
 rtl/mel_pkg.sv | 17 +
 rtl/mel_skid_fifo.sv | 59 +++++
 rtl/mel_frame_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mel_pkg.sv
// mel_pkg -- shared definitions for the mel frame reader.
//   reader_state_t : 2-bit state of the frame reader FSM
//   MEL_BINS_DEF   : default number of mel values per frame
//   DATA_W_DEF     : default width of one log-mel value
package mel_pkg;

    localparam int MEL_BINS_DEF = 40;
    localparam int DATA_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ACK   = 2'd3
    } reader_state_t;

endpackage

// File: rtl/mel_skid_fifo.sv
// mel_skid_fifo -- 2-entry FIFO between the buffer read port and the stream.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : drop all entries (takes priority over push/pop)
//   push/push_data : write one entry
//   pop            : retire the head entry
//   head_data      : current head entry (meaningful when count != 0)
//   count          : number of entries held, 0..2
// Push and pop in the same cycle on a full FIFO is legal: the pop frees
// the slot the push writes into.
module mel_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the two storage words are reset on purpose so the stream
            // data output reads 0 out of reset; larger memories would not be.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/mel_frame_reader.sv
// mel_frame_reader -- reads one frame of MEL_BINS log-mel values out of the
// output buffer and streams them toward the CNN with a valid/ready handshake.
//   clk, reset      : clock, synchronous active-high reset
//   output_valid_i  : buffer holds a complete frame (low mid-frame aborts)
//   rd_en_o/rd_idx_o: buffer read strobe and index
//   rd_data_i       : read data, valid the cycle after rd_en_o
//   frame_sent_o    : one-cycle pulse once the whole frame was accepted
//   m_valid_o/m_ready_i/m_data_o/m_last_o : stream toward the CNN
//   frame_cnt_o     : completed-frame counter, only present when the macro
//                     MEL_READER_FRAME_CNT_EN is defined
module mel_frame_reader
    import mel_pkg::*;
#(
    parameter int MEL_BINS = MEL_BINS_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        output_valid_i,
    output logic                        rd_en_o,
    output logic [$clog2(MEL_BINS)-1:0] rd_idx_o,
    input  logic [DATA_W-1:0]           rd_data_i,
    output logic                        frame_sent_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [DATA_W-1:0]           m_data_o,
    output logic                        m_last_o
`ifdef MEL_READER_FRAME_CNT_EN
    ,
    output logic [15:0]                 frame_cnt_o
`endif
);

    localparam int               IDX_W    = $clog2(MEL_BINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEL_BINS - 1);

    reader_state_t    state;
    logic [IDX_W-1:0] rd_idx;
    logic             inflight;       // read issued last cycle, data on rd_data_i now
    logic             inflight_last;  // that read was for the last bin
    logic [1:0]       fifo_count;
    logic [DATA_W:0]  fifo_head;
    logic             pop;
    logic             push;
    logic             abort;
    logic             issue;

    assign m_valid_o = (fifo_count != 2'd0);
    assign m_data_o  = fifo_head[DATA_W-1:0];
    assign m_last_o  = fifo_head[DATA_W];
    assign pop       = m_valid_o && m_ready_i;

    assign abort = ((state == ST_FETCH) || (state == ST_DRAIN)) && !output_valid_i;

    // Credit check: what the FIFO will hold after this edge (held + landing
    // - leaving) must leave room for the read issued now. It uses this
    // cycle's pop so a steady stream sustains one value per cycle with only
    // two entries; that makes rd_en_o combinational on m_ready_i.
    assign issue = (state == ST_FETCH) && output_valid_i &&
                   (({1'b0, fifo_count} + 3'(inflight) - 3'(pop)) < 3'd2);

    assign rd_en_o  = issue;
    assign rd_idx_o = rd_idx;
    assign push     = inflight && !abort;

    mel_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (push),
        .push_data ({inflight_last, rd_data_i}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rd_idx        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            frame_sent_o  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below sees the values from before this edge.
            inflight      <= issue;
            inflight_last <= issue && (rd_idx == LAST_IDX);
            frame_sent_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // also wraps the index left at the last bin by the previous frame
                    rd_idx <= '0;
                    if (output_valid_i) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (issue) begin
                        if (rd_idx == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (pop && m_last_o) begin
                        state        <= ST_ACK;
                        frame_sent_o <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEL_READER_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= 16'd0;
        end else if (frame_sent_o) begin
            frame_cnt <= frame_cnt + 16'd1;  // wraps 0xFFFF -> 0
        end
    end

    assign frame_cnt_o = frame_cnt;
`endif

endmodule
